// File: rtl/ace_mem_pkg.sv
// Shared types and constants for the Ace memory arbiter: regions, FSM states, map limits.
package ace_mem_pkg;

  localparam int unsigned WS_W   = 3;
  localparam int unsigned VCNT_W = 8;
  localparam int unsigned EN_W   = 6;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_ROM,
    REG_SCR,
    REG_CHR,
    REG_URAM,
    REG_XRAM,
    REG_ERAM
  } region_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VWAIT,
    ST_WS,
    ST_DONE
  } state_e;

  localparam logic [15:0] ROM_BASE   = 16'h0000;
  localparam logic [15:0] ROM_LIMIT  = 16'h1FFF;
  localparam logic [15:0] SCR_BASE   = 16'h2000;
  localparam logic [15:0] SCR_LIMIT  = 16'h27FF;
  localparam logic [15:0] CHR_BASE   = 16'h2800;
  localparam logic [15:0] CHR_LIMIT  = 16'h2FFF;
  localparam logic [15:0] URAM_BASE  = 16'h3000;
  localparam logic [15:0] URAM_LIMIT = 16'h3FFF;
  localparam logic [15:0] XRAM_BASE  = 16'h4000;
  localparam logic [15:0] XRAM_LIMIT = 16'h7FFF;
  localparam logic [15:0] ERAM_BASE  = 16'h8000;
  localparam logic [15:0] ERAM_LIMIT = 16'hFFFF;

  // Inclusive address window test
  function automatic logic in_range(logic [15:0] a, logic [15:0] base, logic [15:0] limit);
    return (a >= base) && (a <= limit);
  endfunction

endpackage

// File: rtl/ace_addr_decode.sv
// Combinational Z80 address decode into a memory region plus video-contention flag.
module ace_addr_decode
  import ace_mem_pkg::*;
#(
  parameter bit XRAM_EN    = 1'b1,
  parameter bit ERAM_EN    = 1'b0,
  parameter bit CONTENTION = 1'b1
) (
  input  logic [15:0] cpu_addr,
  output region_e     region_c,
  output logic        contended_c
);

  // Region lookup; only the low screen/char mirrors (a[10]=0) contend with video
  always_comb begin
    region_c = REG_NONE;
    if (in_range(cpu_addr, ROM_BASE, ROM_LIMIT))                   region_c = REG_ROM;
    else if (in_range(cpu_addr, SCR_BASE, SCR_LIMIT))              region_c = REG_SCR;
    else if (in_range(cpu_addr, CHR_BASE, CHR_LIMIT))              region_c = REG_CHR;
    else if (in_range(cpu_addr, URAM_BASE, URAM_LIMIT))            region_c = REG_URAM;
    else if (XRAM_EN && in_range(cpu_addr, XRAM_BASE, XRAM_LIMIT)) region_c = REG_XRAM;
    else if (ERAM_EN && in_range(cpu_addr, ERAM_BASE, ERAM_LIMIT)) region_c = REG_ERAM;
    contended_c = CONTENTION && ((region_c == REG_SCR) || (region_c == REG_CHR)) && !cpu_addr[10];
  end

endmodule

// File: rtl/ace_mem_arbiter.sv
// Ace memory arbiter: region enables, contention/wait-state stretching, read data register, write gating.
module ace_mem_arbiter
  import ace_mem_pkg::*;
#(
  parameter bit          XRAM_EN       = 1'b1,
  parameter bit          ERAM_EN       = 1'b0,
  parameter bit          ROM_WRITABLE  = 1'b0,
  parameter bit          CONTENTION    = 1'b1,
  parameter int unsigned ROM_WS        = 0,
  parameter int unsigned XRAM_WS       = 0,
  parameter int unsigned ERAM_WS       = 1,
  parameter int unsigned VWAIT_TIMEOUT = 255,
  parameter logic [7:0]  FLOAT_VALUE   = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic        mreq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        video_busy,
  input  logic        io_oe,
  input  logic [7:0]  io_data,
  input  logic [7:0]  dout_rom,
  input  logic [7:0]  dout_sram,
  input  logic [7:0]  dout_cram,
  input  logic [7:0]  dout_uram,
  input  logic [7:0]  dout_xram,
  input  logic [7:0]  dout_eram,
  output logic        rom_en,
  output logic        sram_en,
  output logic        cram_en,
  output logic        uram_en,
  output logic        xram_en,
  output logic        eram_en,
  output logic        mem_we,
  output logic        wait_n,
  output logic [7:0]  data_to_cpu,
  output logic        vwait_ovf
);

  region_e           dec_region, region_q, region_d, sel_region;
  logic              dec_contended;
  state_e            state_q, state_d;
  logic [WS_W-1:0]   cnt_q, cnt_d, ws_sel;
  logic [VCNT_W-1:0] vcnt_q, vcnt_d;
  logic [EN_W-1:0]   en_q, en_d;
  logic [7:0]        data_q, data_d, rd_mux;
  logic              wait_n_d, mem_we_d, ovf_d, advance;

  function automatic logic [WS_W-1:0] ws_of(region_e r);
    case (r)
      REG_ROM:  return WS_W'(ROM_WS);
      REG_XRAM: return WS_W'(XRAM_WS);
      REG_ERAM: return WS_W'(ERAM_WS);
      default:  return '0;
    endcase
  endfunction

  function automatic logic [EN_W-1:0] onehot(region_e r);
    case (r)
      REG_ROM:  return EN_W'(6'b100000);
      REG_SCR:  return EN_W'(6'b010000);
      REG_CHR:  return EN_W'(6'b001000);
      REG_URAM: return EN_W'(6'b000100);
      REG_XRAM: return EN_W'(6'b000010);
      REG_ERAM: return EN_W'(6'b000001);
      default:  return '0;
    endcase
  endfunction

  ace_addr_decode #(
    .XRAM_EN    (XRAM_EN),
    .ERAM_EN    (ERAM_EN),
    .CONTENTION (CONTENTION)
  ) u_decode (
    .cpu_addr    (cpu_addr),
    .region_c    (dec_region),
    .contended_c (dec_contended)
  );

  // Read-data select for the region being completed
  always_comb begin
    case (sel_region)
      REG_ROM:  rd_mux = dout_rom;
      REG_SCR:  rd_mux = dout_sram;
      REG_CHR:  rd_mux = dout_cram;
      REG_URAM: rd_mux = dout_uram;
      REG_XRAM: rd_mux = dout_xram;
      REG_ERAM: rd_mux = dout_eram;
      default:  rd_mux = FLOAT_VALUE;
    endcase
  end

  // Next state and next registered outputs; region is frozen once the cycle leaves IDLE
  always_comb begin
    sel_region = (state_q == ST_IDLE) ? dec_region : region_q;
    ws_sel     = ws_of(sel_region);
    region_d   = sel_region;
    state_d    = state_q;
    cnt_d      = cnt_q;
    vcnt_d     = vcnt_q;
    ovf_d      = vwait_ovf;
    advance    = 1'b0;
    if (mreq_n) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      vcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dec_contended && video_busy) begin
            state_d = ST_VWAIT;
            vcnt_d  = VCNT_W'(1);
          end else begin
            advance = 1'b1;
          end
        end
        ST_VWAIT: begin
          if (!video_busy || (vcnt_q == VCNT_W'(VWAIT_TIMEOUT))) begin
            ovf_d   = vwait_ovf | video_busy;
            vcnt_d  = '0;
            advance = 1'b1;
          end else begin
            vcnt_d = vcnt_q + VCNT_W'(1);
          end
        end
        ST_WS: begin
          if (cnt_q == '0) state_d = ST_DONE;
          else             cnt_d   = cnt_q - WS_W'(1);
        end
        default: ;
      endcase
      if (advance) begin
        if (ws_sel != '0) begin
          state_d = ST_WS;
          cnt_d   = ws_sel - WS_W'(1);
        end else begin
          state_d = ST_DONE;
        end
      end
    end
    wait_n_d = !((state_d == ST_VWAIT) || (state_d == ST_WS));
    en_d     = (state_d == ST_IDLE) ? '0 : onehot(region_d);
    mem_we_d = !wr_n && (state_d == ST_DONE) && (region_d != REG_NONE) &&
               ((region_d != REG_ROM) || ROM_WRITABLE);
    data_d   = ((state_d == ST_DONE) && (state_q != ST_DONE) && !rd_n) ? rd_mux : data_q;
  end

  // State, counters and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      region_q  <= REG_NONE;
      cnt_q     <= '0;
      vcnt_q    <= '0;
      en_q      <= '0;
      wait_n    <= 1'b1;
      mem_we    <= 1'b0;
      data_q    <= FLOAT_VALUE;
      vwait_ovf <= 1'b0;
    end else begin
      state_q   <= state_d;
      region_q  <= region_d;
      cnt_q     <= cnt_d;
      vcnt_q    <= vcnt_d;
      en_q      <= en_d;
      wait_n    <= wait_n_d;
      mem_we    <= mem_we_d;
      data_q    <= data_d;
      vwait_ovf <= ovf_d;
    end
  end

  assign {rom_en, sram_en, cram_en, uram_en, xram_en, eram_en} = en_q;

  // I/O read data bypasses the memory data register
  assign data_to_cpu = io_oe ? io_data : data_q;

endmodule

// File: tb/tb_ace_mem_arbiter.sv
// Scoreboard bench for ace_mem_arbiter: stimulus pushes expected cycle outcomes, a monitor pops and compares.
module tb_ace_mem_arbiter;

  localparam bit          XRAM_EN       = 1'b0;
  localparam bit          ERAM_EN       = 1'b1;
  localparam bit          ROM_WRITABLE  = 1'b0;
  localparam bit          CONTENTION    = 1'b1;
  localparam int unsigned ROM_WS        = 2;
  localparam int unsigned XRAM_WS       = 4;
  localparam int unsigned ERAM_WS       = 3;
  localparam int unsigned VWAIT_TIMEOUT = 13;
  localparam logic [7:0]  FLOAT_VALUE   = 8'hFF;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_addr;
  logic        mreq_n, rd_n, wr_n, video_busy, io_oe;
  logic [7:0]  io_data;
  logic [7:0]  dval [0:6];
  logic        rom_en, sram_en, cram_en, uram_en, xram_en, eram_en;
  logic        mem_we, wait_n, vwait_ovf;
  logic [7:0]  data_to_cpu;
  logic [5:0]  en_now;

  assign en_now = {rom_en, sram_en, cram_en, uram_en, xram_en, eram_en};

  ace_mem_arbiter #(
    .XRAM_EN(XRAM_EN), .ERAM_EN(ERAM_EN), .ROM_WRITABLE(ROM_WRITABLE), .CONTENTION(CONTENTION),
    .ROM_WS(ROM_WS), .XRAM_WS(XRAM_WS), .ERAM_WS(ERAM_WS), .VWAIT_TIMEOUT(VWAIT_TIMEOUT),
    .FLOAT_VALUE(FLOAT_VALUE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .mreq_n(mreq_n), .rd_n(rd_n), .wr_n(wr_n),
    .video_busy(video_busy), .io_oe(io_oe), .io_data(io_data),
    .dout_rom(dval[1]), .dout_sram(dval[2]), .dout_cram(dval[3]), .dout_uram(dval[4]),
    .dout_xram(dval[5]), .dout_eram(dval[6]),
    .rom_en(rom_en), .sram_en(sram_en), .cram_en(cram_en), .uram_en(uram_en),
    .xram_en(xram_en), .eram_en(eram_en), .mem_we(mem_we), .wait_n(wait_n),
    .data_to_cpu(data_to_cpu), .vwait_ovf(vwait_ovf)
  );

  always #5 clk = ~clk;

  typedef enum int {R_NONE = 0, R_ROM, R_SCR, R_CHR, R_URAM, R_XRAM, R_ERAM} reg_t;

  typedef struct {
    int         low;
    logic [5:0] en;
    logic       we;
    logic [7:0] data;
    logic       ovf;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] io_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_data = FLOAT_VALUE;
  logic       m_ovf  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference memory map
  function automatic reg_t region_of(input logic [15:0] a);
    if (a < 16'h2000) return R_ROM;
    if (a < 16'h2800) return R_SCR;
    if (a < 16'h3000) return R_CHR;
    if (a < 16'h4000) return R_URAM;
    if (a < 16'h8000) return XRAM_EN ? R_XRAM : R_NONE;
    return ERAM_EN ? R_ERAM : R_NONE;
  endfunction

  function automatic int ws_of(input reg_t r);
    if (r == R_ROM)  return int'(ROM_WS);
    if (r == R_XRAM) return int'(XRAM_WS);
    if (r == R_ERAM) return int'(ERAM_WS);
    return 0;
  endfunction

  function automatic logic [5:0] en_of(input reg_t r);
    logic [5:0] v;
    v = 6'b0;
    if (r != R_NONE) v[6 - int'(r)] = 1'b1;
    return v;
  endfunction

  // One CPU memory cycle; abort_at>0 releases mreq_n after that many clocks if still waiting
  task automatic mem_cycle(input logic [15:0] addr, input bit wr, input int run, input int abort_at);
    reg_t r;
    bit   cont, tout;
    int   vw, total, n, gap;
    exp_t e;
    r    = region_of(addr);
    cont = CONTENTION && (r == R_SCR || r == R_CHR) && !addr[10];
    vw   = 0;
    tout = 1'b0;
    if (cont && run > 0) begin
      if (run > int'(VWAIT_TIMEOUT)) begin vw = int'(VWAIT_TIMEOUT); tout = 1'b1; end
      else vw = run;
    end
    total = vw + ws_of(r);
    if (abort_at >= total) abort_at = 0;
    @(negedge clk);
    for (int i = 1; i <= 6; i++) dval[i] = 8'($urandom);
    io_oe      = 1'b0;
    cpu_addr   = addr;
    mreq_n     = 1'b0;
    rd_n       = wr;
    wr_n       = !wr;
    video_busy = (run > 0);
    e.low = (abort_at > 0) ? abort_at : total;
    e.en  = en_of(r);
    e.we  = wr && (abort_at == 0) && (r != R_NONE) && (r != R_ROM || ROM_WRITABLE);
    if (!wr && abort_at == 0) m_data = (r == R_NONE) ? FLOAT_VALUE : dval[int'(r)];
    if (tout && abort_at == 0) m_ovf = 1'b1;
    e.data = m_data;
    e.ovf  = m_ovf;
    exp_q.push_back(e);
    n = 0;
    if (abort_at > 0) begin
      repeat (abort_at) begin
        @(negedge clk);
        n++;
        video_busy = (n < run);
        if (n == 1) cpu_addr = 16'($urandom);
      end
    end else begin
      do begin
        @(negedge clk);
        n++;
        video_busy = (n < run);
        if (n == 1) cpu_addr = 16'($urandom);
      end while (wait_n !== 1'b1 && n < 300);
      if (wait_n !== 1'b1) check("wait_release_bound", 32'(wait_n), 32'd1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    mreq_n     = 1'b1;
    rd_n       = 1'b1;
    wr_n       = 1'b1;
    video_busy = 1'b0;
    gap = $urandom_range(1, 3);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      io_oe = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        io_data = 8'($urandom);
        io_oe   = 1'b1;
        io_q.push_back(io_data);
      end
    end
  endtask

  // Monitor: accumulate each memory cycle and compare when mreq_n is seen released
  bit         in_cyc = 1'b0;
  bit         multi;
  int         low_cnt;
  logic [5:0] en_seen;
  logic       we_seen;
  exp_t       got_e;

  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      in_cyc = 1'b0;
    end else if (!mreq_n) begin
      if (!in_cyc) begin
        in_cyc = 1'b1; low_cnt = 0; en_seen = 6'b0; we_seen = 1'b0; multi = 1'b0;
      end
      if (wait_n === 1'b0) low_cnt++;
      en_seen = en_seen | en_now;
      we_seen = we_seen | mem_we;
      if ($countones(en_now) > 1) multi = 1'b1;
    end else if (in_cyc) begin
      in_cyc = 1'b0;
      if (exp_q.size() == 0) begin
        check("unexpected_cycle", 32'd1, 32'd0);
      end else begin
        got_e = exp_q.pop_front();
        check("wait_low_cycles", 32'(low_cnt), 32'(got_e.low));
        check("enables_seen", 32'(en_seen), 32'(got_e.en));
        check("mem_we_seen", 32'(we_seen), 32'(got_e.we));
        check("data_to_cpu", 32'(data_to_cpu), 32'(got_e.data));
        check("vwait_ovf", 32'(vwait_ovf), 32'(got_e.ovf));
        check("enables_onehot", 32'(multi), 32'd0);
        check("idle_outputs", 32'({wait_n, en_now, mem_we}), 32'({1'b1, 6'b0, 1'b0}));
      end
    end
    if (reset_n && io_oe) begin
      if (io_q.size() == 0) check("unexpected_io", 32'd1, 32'd0);
      else check("io_bypass", 32'(data_to_cpu), 32'(io_q.pop_front()));
    end
  end

  typedef struct { logic [15:0] addr; bit wr; int run; } dir_t;
  dir_t dir_tab[$] = '{
    '{16'h2010, 1'b0, 12}, '{16'h2410, 1'b0, 12}, '{16'h9000, 1'b0, 0},
    '{16'h0100, 1'b1, 0},  '{16'h5000, 1'b0, 0},  '{16'h3C05, 1'b0, 0},
    '{16'h0200, 1'b0, 0},  '{16'h2A00, 1'b0, 30}, '{16'h2800, 1'b1, 3},
    '{16'h2C00, 1'b0, 5},  '{16'h9000, 1'b1, 0},  '{16'h3005, 1'b1, 0},
    '{16'h2300, 1'b0, 13}, '{16'h2300, 1'b0, 14}
  };

  initial begin
    logic [15:0] a;
    int          ab;
    reset_n = 1'b1; cpu_addr = 16'h0; mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    video_busy = 1'b0; io_oe = 1'b0; io_data = 8'h0;
    for (int i = 0; i <= 6; i++) dval[i] = 8'h00;
    #2 reset_n = 1'b0;
    #1;
    check("reset_wait_n", 32'(wait_n), 32'd1);
    check("reset_enables", 32'(en_now), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_data", 32'(data_to_cpu), 32'(FLOAT_VALUE));
    check("reset_ovf", 32'(vwait_ovf), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (dir_tab[i]) mem_cycle(dir_tab[i].addr, dir_tab[i].wr, dir_tab[i].run, 0);
    mem_cycle(16'h9000, 1'b0, 0, 2);
    mem_cycle(16'h2100, 1'b0, 8, 4);

    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 2))
        0:       a = 16'h2000 + 16'($urandom_range(0, 16'h0FFF));
        1:       a = 16'($urandom_range(0, 16'h3FFF));
        default: a = 16'($urandom);
      endcase
      ab = ($urandom_range(0, 6) == 0) ? $urandom_range(1, 6) : 0;
      mem_cycle(a, ($urandom_range(0, 2) == 0), $urandom_range(0, 18), ab);
    end

    // Reset asserted while the CPU is held in a contention wait
    mem_cycle(16'h2A10, 1'b0, 20, 0);
    @(negedge clk);
    dval[2] = 8'h5A;
    cpu_addr = 16'h2100; mreq_n = 1'b0; rd_n = 1'b0; video_busy = 1'b1;
    @(negedge clk);
    check("vwait_entered", 32'(wait_n), 32'd0);
    @(negedge clk);
    #2;
    reset_n = 1'b0; mreq_n = 1'b1; rd_n = 1'b1; video_busy = 1'b0;
    #1;
    check("midreset_wait_n", 32'(wait_n), 32'd1);
    check("midreset_enables", 32'(en_now), 32'd0);
    check("midreset_data", 32'(data_to_cpu), 32'(FLOAT_VALUE));
    check("midreset_ovf", 32'(vwait_ovf), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    m_data = FLOAT_VALUE;
    m_ovf  = 1'b0;
    mem_cycle(16'h5000, 1'b1, 0, 0);
    mem_cycle(16'h2010, 1'b0, 3, 0);
    mem_cycle(16'h0000, 1'b0, 0, 0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("io_drained", 32'(io_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ace_mem_arbiter.md
Name: ace_mem_arbiter

Overview:
Parametrised successor to the Ace top-level address decoder and read-data mux. It decodes Z80 memory cycles into one-hot region enables and stretches cycles with wait_n, for two reasons: video contention on the low screen/char mirrors, and per-region programmable wait states. It registers the read data returned to the CPU and gates memory writes, including ROM write-protect. It sits between the CPU bus and the ROM/screen/char/user/expansion RAMs, replacing the flat priority mux.

Parameters:
XRAM_EN, 1, map 16K expansion RAM at 4000-7FFF (0: unmapped)
ERAM_EN, 0, map 32K RAM at 8000-FFFF (0: unmapped)
ROM_WRITABLE, 0, 1 allows writes to ROM region
CONTENTION, 1, enable video-contention waits on 2000-23FF and 2800-2BFF
ROM_WS, 0, ROM wait states, 0-7
XRAM_WS, 0, XRAM wait states, 0-7
ERAM_WS, 1, ERAM wait states, 0-7
VWAIT_TIMEOUT, 255, maximum contention wait cycles before forced completion (1-255)
FLOAT_VALUE, 8'hFF, read value for unmapped addresses

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cpu_addr  in  16  Z80 address bus
mreq_n  in  1  Z80 memory request
rd_n  in  1  Z80 read strobe
wr_n  in  1  Z80 write strobe
video_busy  in  1  video fetch in progress (from jace_logic)
io_oe  in  1  I/O read data valid from jace_logic
io_data  in  8  I/O read data
dout_rom, dout_sram, dout_cram, dout_uram, dout_xram, dout_eram  in  8 each  region read data
rom_en, sram_en, cram_en, uram_en, xram_en, eram_en  out  1 each  one-hot region enables
mem_we  out  1  gated write enable to all regions
wait_n  out  1  Z80 wait, active low
data_to_cpu  out  8  CPU read data
vwait_ovf  out  1  sticky: contention timeout occurred

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous, active-low on reset_n.
- Reset values: state IDLE, wait_n=1, mem_we=0, all enables 0, data_to_cpu=FLOAT_VALUE, vwait_ovf=0, counters 0.
- Address decode (combinational, qualified by ~mreq_n):
  - 0000-1FFF ROM.
  - 2000-27FF screen (a[9:0]).
  - 2800-2FFF char.
  - 3000-3FFF URAM, 1K mirrored x4.
  - 4000-7FFF XRAM if XRAM_EN.
  - 8000-FFFF ERAM if ERAM_EN.
  - Anything else: NONE.
  - contended = CONTENTION & (screen|char) & ~a[10].
- FSM states: IDLE, VWAIT, WS, DONE.
- IDLE: on a clk edge with mreq_n=0:
  - contended & video_busy -> VWAIT.
  - else WS(region)>0 -> WS with cnt=WS-1.
  - else -> DONE.
  - WS(screen/char/uram/NONE)=0.
- wait_n is registered. It is 0 in VWAIT and WS, and 1 in IDLE and DONE. The next-state decision drives it, so wait_n falls in the first clk after mreq_n is sampled low.
- VWAIT: leaves when video_busy=0 (to WS or DONE as above), or after VWAIT_TIMEOUT cycles. Timeout forces progress and sets vwait_ovf, which is sticky until reset.
- WS: cnt decrements each clk; at cnt=0 -> DONE. Total wait_n-low cycles = WS(region) (+ contention cycles).
- DONE, on entry:
  - If rd_n=0, data_to_cpu latches the selected region dout (FLOAT_VALUE if NONE).
  - data_to_cpu holds until the next DONE entry.
  - Stay in DONE until mreq_n=1, then -> IDLE.
- Enables: asserted from the IDLE-exit clk through DONE, for the decoded region only. Decode is frozen at IDLE exit; cpu_addr changes during the cycle are ignored.
- mem_we = ~wr_n & state==DONE & region!=NONE & (region!=ROM | ROM_WRITABLE). A ROM write with ROM_WRITABLE=0 completes normally with no write.
- mreq_n rising in any state: next clk goes to IDLE with wait_n=1 and counters cleared (abort). data_to_cpu is unchanged.
- I/O: when io_oe=1, data_to_cpu outputs io_data combinationally (bypass). No waits are inserted; the FSM ignores cycles with mreq_n=1.
- Back-to-back: a new mreq_n low sampled in the same clk as the IDLE return is handled on the following clk (one idle clk minimum).

Decomposition:
- ace_mem_pkg holds:
  - region enum (REG_NONE, REG_ROM, REG_SCR, REG_CHR, REG_URAM, REG_XRAM, REG_ERAM).
  - region base/limit constants.
  - FSM state enum.
  - WS width (3).
- Sub-module ace_addr_decode (combinational): cpu_addr plus the enable parameters in; region and contended out.

Test Plan:
- Reset mid-VWAIT (reset_n low while wait_n=0) -> wait_n=1, enables 0, data_to_cpu=FF, vwait_ovf=0 immediately.
- Read 0x2010 with video_busy=1 for 12 clks -> wait_n low 12 clks, then data_to_cpu=dout_sram (e.g. 5A). The same read at 0x2410 -> no wait.
- ERAM_EN=1, ERAM_WS=3, read 0x9000 -> wait_n low exactly 3 clks, eram_en only, data_to_cpu=dout_eram.
- ROM_WRITABLE=0, write 0x0100 -> mem_we never 1, no wait. With ROM_WRITABLE=1 -> mem_we=1 in DONE.
- XRAM_EN=0, read 0x5000 -> all enables 0, data_to_cpu=FF. Read 0x3C05 -> uram_en, URAM addressed at 0x005 (mirror).
- VWAIT_TIMEOUT=4 with video_busy stuck at 1 -> wait_n low 4 clks, DONE reached, vwait_ovf=1 and stays 1 across later cycles.
